// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID-stage hazard controller.
// The MDU stall logic is enabled by defining HAZARD_MDU_STALL_EN.
package hazard_pkg;

    localparam logic [1:0] JUMP_JR  = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        MDU_IDLE,
        MDU_BUSY
    } mdu_state_e;

    // An EX-stage write to $zero never creates a dependency.
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] wa,
                                       input logic [4:0] ra);
        return we && (wa != REG_ZERO) && (wa == ra);
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// Tracks a multi-cycle mult/div: IDLE/BUSY FSM with a down-counter.
// Only instantiated when HAZARD_MDU_STALL_EN is defined.
module mdu_timer
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic busy_o,
    output logic ready_next_o
);

    localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MDU_LAT - 1);

    mdu_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    // A start pulse while busy is ignored; the ID stage should never issue one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (start_i) begin
                        state_q <= MDU_BUSY;
                        cnt_q   <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= MDU_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= MDU_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign ready_next_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage stall/flush controller: load-use, JR-on-EX-producer and HI/LO hazards.
// Define HAZARD_MDU_STALL_EN to compile in the multi-cycle MDU tracking.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             id_uses_rt,
    input  logic [1:0]       Jump,
    input  logic             id_uses_hilo,
    input  logic [4:0]       rf_wa_ex,
    input  logic             RegWrite_ex,
    input  logic             MemRead_ex,
    input  logic             branch_taken,
    input  logic             mdu_start,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count
);

    logic dep_rs, dep_rt;
    logic lu, jr, hilo, stall;
    logic [CNT_W-1:0] count_q, count_d;

    assign dep_rs = reg_match(RegWrite_ex, rf_wa_ex, rs);
    assign dep_rt = id_uses_rt && reg_match(RegWrite_ex, rf_wa_ex, rt);

    assign lu = MemRead_ex && (dep_rs || dep_rt);
    assign jr = (Jump == JUMP_JR) && dep_rs && !MemRead_ex;

`ifdef HAZARD_MDU_STALL_EN
    logic mdu_ready_next;

    mdu_timer #(
        .MDU_LAT(MDU_LAT)
    ) u_mdu_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (mdu_start),
        .busy_o      (mdu_busy),
        .ready_next_o(mdu_ready_next)
    );

    assign hilo = id_uses_hilo && mdu_busy && !mdu_ready_next;
`else
    logic unused_mdu;

    assign unused_mdu = mdu_start ^ id_uses_hilo ^ (MDU_LAT < 2);
    assign hilo       = 1'b0;
    assign mdu_busy   = 1'b0;
`endif

    assign stall = lu || jr || hilo;

    // A taken branch squashes the wrong-path ID instruction, so any stall it raised is moot.
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (!rst_n) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (branch_taken) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (stall) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign count_d = PCWrite ? count_q : count_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stall_count = count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model. Follows HAZARD_MDU_STALL_EN like the RTL.
module tb_hazard_ctrl;

    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;

`ifdef HAZARD_MDU_STALL_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [4:0]       rs, rt, rf_wa_ex;
    logic             id_uses_rt, id_uses_hilo, RegWrite_ex, MemRead_ex;
    logic [1:0]       Jump;
    logic             branch_taken, mdu_start;
    logic             PCWrite, IFIDWrite, idex_bubble, ifid_flush, mdu_busy;
    logic [CNT_W-1:0] stall_count;

    int testCount = 0;
    int failCount = 0;

    // Reference model state: busy cycles still to run, and stall cycles seen.
    int mduLeft  = 0;
    int stallCnt = 0;

    hazard_ctrl #(
        .MDU_LAT(MDU_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs          (rs),
        .rt          (rt),
        .id_uses_rt  (id_uses_rt),
        .Jump        (Jump),
        .id_uses_hilo(id_uses_hilo),
        .rf_wa_ex    (rf_wa_ex),
        .RegWrite_ex (RegWrite_ex),
        .MemRead_ex  (MemRead_ex),
        .branch_taken(branch_taken),
        .mdu_start   (mdu_start),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .idex_bubble (idex_bubble),
        .ifid_flush  (ifid_flush),
        .mdu_busy    (mdu_busy),
        .stall_count (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        rs = 5'd0; rt = 5'd0; rf_wa_ex = 5'd0;
        id_uses_rt = 1'b0; id_uses_hilo = 1'b0; RegWrite_ex = 1'b0; MemRead_ex = 1'b0;
        Jump = 2'b00; branch_taken = 1'b0; mdu_start = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_pc"},     PCWrite,     0);
        checkOutput({tag, "_ifid"},   IFIDWrite,   0);
        checkOutput({tag, "_bubble"}, idex_bubble, 1);
        checkOutput({tag, "_flush"},  ifid_flush,  1);
        checkOutput({tag, "_busy"},   mdu_busy,    0);
        checkOutput({tag, "_count"},  stall_count, 0);
    endtask

    // One pipeline cycle: drive ID/EX state, check the combinational decision,
    // then advance the model across the rising edge and check the registered outputs.
    task automatic applyStimulus(input string tag,
                                 input logic [4:0] aRs, input logic [4:0] aRt,
                                 input logic aUsesRt, input logic [1:0] aJump,
                                 input logic aHilo, input logic [4:0] aWa,
                                 input logic aRw, input logic aMr,
                                 input logic aBt, input logic aStart);
        logic depRs, depRt, isStall;
        logic expPc, expIfid, expBubble, expFlush;
        @(negedge clk);
        rs = aRs; rt = aRt; id_uses_rt = aUsesRt; Jump = aJump; id_uses_hilo = aHilo;
        rf_wa_ex = aWa; RegWrite_ex = aRw; MemRead_ex = aMr; branch_taken = aBt;
        mdu_start = aStart;
        #1;
        depRs   = aRw && (aWa != 0) && (aWa == aRs);
        depRt   = aUsesRt && aRw && (aWa != 0) && (aWa == aRt);
        isStall = (aMr && (depRs || depRt))
               || ((aJump == 2'b10) && depRs && !aMr)
               || (MDU_EN && aHilo && (mduLeft > 1));
        if (aBt) begin
            expPc = 1; expIfid = 1; expBubble = 1; expFlush = 1;
        end else if (isStall) begin
            expPc = 0; expIfid = 0; expBubble = 1; expFlush = 0;
        end else begin
            expPc = 1; expIfid = 1; expBubble = 0; expFlush = 0;
        end
        checkOutput({tag, "_pc"},     PCWrite,     expPc);
        checkOutput({tag, "_ifid"},   IFIDWrite,   expIfid);
        checkOutput({tag, "_bubble"}, idex_bubble, expBubble);
        checkOutput({tag, "_flush"},  ifid_flush,  expFlush);
        @(posedge clk);
        if (!expPc) stallCnt = (stallCnt + 1) % (1 << CNT_W);
        if (mduLeft > 0) mduLeft--;
        else if (MDU_EN && aStart) mduLeft = MDU_LAT;
        #1;
        checkOutput({tag, "_count"}, stall_count, stallCnt);
        checkOutput({tag, "_busy"},  mdu_busy,    (mduLeft > 0) ? 1 : 0);
    endtask

    task automatic applyLoadUse(input string tag);
        applyStimulus(tag, 5'd8, 5'd0, 1'b1, 2'b00, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int countBefore;
        idleInputs();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 checkResetOutputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mduLeft = 0; stallCnt = 0;

        // lw $t0 in EX, add using $t0 in ID
        applyLoadUse("t1_lu");
        checkOutput("t1_count", stall_count, 1);
        // rt-side load-use, and rt ignored when the instruction does not read it
        applyStimulus("t1_lu_rt", 5'd3, 5'd8, 1'b1, 2'b00, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("t1_nort",  5'd3, 5'd8, 1'b0, 2'b00, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);

        // jr on an EX ALU producer, then the $zero case
        applyStimulus("t2_jr",   5'd9, 5'd0, 1'b0, 2'b10, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("t2_zero", 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("t2_jrlw", 5'd9, 5'd0, 1'b0, 2'b10, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);

        // branch redirect overrides a load-use stall
        countBefore = int'(stall_count);
        applyStimulus("t3_bt", 5'd8, 5'd0, 1'b1, 2'b00, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_count", stall_count, countBefore);

        // mult then mflo: three stall cycles when MDU tracking is built in
        countBefore = int'(stall_count);
        applyStimulus("t4_start", 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            applyStimulus("t4_mflo", 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_stalls", stall_count, (countBefore + (MDU_EN ? 3 : 0)) % 16);

        // asynchronous reset in the middle of a busy period
        applyStimulus("t5_start", 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyLoadUse("t5_lu");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("t5_async");
        idleInputs();
        mduLeft = 0; stallCnt = 0;
        @(posedge clk);
        #1 checkResetOutputs("t5_hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t5_rel_busy",  mdu_busy,    0);
        checkOutput("t5_rel_count", stall_count, 0);

        // 17 stall cycles wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) applyLoadUse("t6_wrap");
        checkOutput("t6_count", stall_count, 1);

        // randomized traffic on a small register window to provoke matches
        for (int i = 0; i < 400; i++) begin
            logic rStart;
            rStart = (mduLeft == 0) && ($urandom_range(0, 7) == 0);
            applyStimulus("rand",
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? 2'b10 : 2'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), rStart);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
